// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader for the 3x3-by-3x1 signed matrix-vector multiply stage.
// Collects 12 framed operands (A row-major, then B_11/B_21/B_31) and holds them under a valid/ready handshake.
module matrix_operand_loader #(
  parameter int NBITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic signed [NBITS-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [NBITS-1:0] A_11,
  output logic signed [NBITS-1:0] A_12,
  output logic signed [NBITS-1:0] A_13,
  output logic signed [NBITS-1:0] A_21,
  output logic signed [NBITS-1:0] A_22,
  output logic signed [NBITS-1:0] A_23,
  output logic signed [NBITS-1:0] A_31,
  output logic signed [NBITS-1:0] A_32,
  output logic signed [NBITS-1:0] A_33,
  output logic signed [NBITS-1:0] B_11,
  output logic signed [NBITS-1:0] B_21,
  output logic signed [NBITS-1:0] B_31,
  output logic                    operands_valid,
  input  logic                    operands_ready,
  output logic [3:0]              fill_count,
  output logic                    load_error
);

  typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_fill_count;
  logic [3:0]              w_cnt_nxt;
  logic                    r_load_error;
  logic                    w_err;
  logic                    w_wr_en;
  logic                    w_xfer;
  logic signed [NBITS-1:0] r_op [12];

  // Flush outranks everything; in FULL the stream is stalled and only operands_ready matters.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_fill_count;
    w_wr_en     = 1'b0;
    w_err       = 1'b0;
    w_xfer      = in_valid && (r_state == S_FILL) && !flush;
    if (flush) begin
      w_state_nxt = S_FILL;
      w_cnt_nxt   = 4'd0;
    end else if (r_state == S_FULL) begin
      if (operands_ready) w_state_nxt = S_FILL;
    end else if (w_xfer) begin
      if (r_fill_count == 4'd11) begin
        w_cnt_nxt = 4'd0;
        if (in_last) begin
          w_wr_en     = 1'b1;
          w_state_nxt = S_FULL;
        end else begin
          w_err = 1'b1;
        end
      end else if (in_last) begin
        w_cnt_nxt = 4'd0;
        w_err     = 1'b1;
      end else begin
        w_wr_en   = 1'b1;
        w_cnt_nxt = r_fill_count + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_fill_count <= 4'd0;
      r_load_error <= 1'b0;
      for (int i = 0; i < 12; i++) r_op[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_count <= w_cnt_nxt;
      r_load_error <= w_err;
      if (w_wr_en) r_op[r_fill_count] <= in_data;
    end
  end

  assign in_ready       = (r_state == S_FILL);
  assign operands_valid = (r_state == S_FULL);
  assign fill_count     = r_fill_count;
  assign load_error     = r_load_error;

  assign A_11 = r_op[0];
  assign A_12 = r_op[1];
  assign A_13 = r_op[2];
  assign A_21 = r_op[3];
  assign A_22 = r_op[4];
  assign A_23 = r_op[5];
  assign A_31 = r_op[6];
  assign A_32 = r_op[7];
  assign A_33 = r_op[8];
  assign B_11 = r_op[9];
  assign B_21 = r_op[10];
  assign B_31 = r_op[11];

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: framing, backpressure, flush and async reset.
module tb_matrix_operand_loader;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush = 1'b0;
  logic signed [7:0]       in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic                    in_ready;
  logic signed [7:0]       A_11, A_12, A_13, A_21, A_22, A_23, A_31, A_32, A_33;
  logic signed [7:0]       B_11, B_21, B_31;
  logic                    operands_valid;
  logic                    operands_ready = 1'b0;
  logic [3:0]              fill_count;
  logic                    load_error;

  int n_chk = 0;
  int n_err = 0;
  logic signed [7:0] ops [12];
  int exp_v [12];

  always #5 clk = ~clk;

  matrix_operand_loader #(.NBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .A_11(A_11), .A_12(A_12), .A_13(A_13), .A_21(A_21), .A_22(A_22), .A_23(A_23),
    .A_31(A_31), .A_32(A_32), .A_33(A_33), .B_11(B_11), .B_21(B_21), .B_31(B_31),
    .operands_valid(operands_valid), .operands_ready(operands_ready),
    .fill_count(fill_count), .load_error(load_error)
  );

  assign ops[0] = A_11;  assign ops[1] = A_12;  assign ops[2]  = A_13;
  assign ops[3] = A_21;  assign ops[4] = A_22;  assign ops[5]  = A_23;
  assign ops[6] = A_31;  assign ops[7] = A_32;  assign ops[8]  = A_33;
  assign ops[9] = B_11;  assign ops[10] = B_21; assign ops[11] = B_31;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one element from the falling edge; returns 1 ns after the edge that takes it.
  task automatic push(input int d, input logic l);
    int n = 0;
    @(negedge clk);
    in_data = 8'(d); in_valid = 1'b1; in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_ops();
    @(negedge clk);
    operands_ready = 1'b1;
    @(posedge clk);
    #1 operands_ready = 1'b0;
  endtask

  task automatic push_frame();
    for (int k = 0; k < 12; k++) push(exp_v[k], k == 11);
  endtask

  task automatic check_ops(input string tag);
    for (int k = 0; k < 12; k++) chk($sformatf("%s_op%0d", tag, k), int'(ops[k]), exp_v[k]);
  endtask

  initial begin
    int c1, c2, c3;
    // Reset state
    #12;
    chk("rst_valid", int'(operands_valid), 0);
    chk("rst_fill", int'(fill_count), 0);
    chk("rst_err", int'(load_error), 0);
    chk("rst_A11", int'(A_11), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    // Nominal frame 1..9, 1,2,3
    for (int k = 0; k < 9; k++) exp_v[k] = k + 1;
    exp_v[9] = 1; exp_v[10] = 2; exp_v[11] = 3;
    for (int k = 0; k < 5; k++) push(exp_v[k], 1'b0);
    chk("nom_fill5", int'(fill_count), 5);
    chk("nom_valid_mid", int'(operands_valid), 0);
    for (int k = 5; k < 12; k++) push(exp_v[k], k == 11);
    chk("nom_valid", int'(operands_valid), 1);
    chk("nom_in_ready", int'(in_ready), 0);
    chk("nom_fill0", int'(fill_count), 0);
    check_ops("nom");
    c1 = A_11 * B_11 + A_12 * B_21 + A_13 * B_31;
    c2 = A_21 * B_11 + A_22 * B_21 + A_23 * B_31;
    c3 = A_31 * B_11 + A_32 * B_21 + A_33 * B_31;
    chk("nom_C11", c1, 14);
    chk("nom_C21", c2, 32);
    chk("nom_C31", c3, 50);

    // Backpressure: new data offered while FULL
    @(negedge clk);
    in_data = 8'sd55; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", int'(in_ready), 0);
    end
    chk("bp_A11", int'(A_11), 1);
    chk("bp_B31", int'(B_31), 3);
    chk("bp_valid", int'(operands_valid), 1);
    @(negedge clk);
    operands_ready = 1'b1;
    @(posedge clk);
    #1 operands_ready = 1'b0;
    chk("bp_rel_valid", int'(operands_valid), 0);
    chk("bp_rel_ready", int'(in_ready), 1);
    chk("bp_rel_fill", int'(fill_count), 0);
    in_valid = 1'b0;

    // Signed extremes
    for (int k = 0; k < 12; k++) exp_v[k] = -128;
    push_frame();
    chk("ext_valid", int'(operands_valid), 1);
    check_ops("ext");
    chk("ext_raw_A22", int'($unsigned(A_22)), 128);
    c1 = A_11 * B_11 + A_12 * B_21 + A_13 * B_31;
    chk("ext_C11", c1, 49152);
    release_ops();

    // Early in_last on the 5th element
    for (int k = 0; k < 4; k++) push(10 + k, 1'b0);
    push(14, 1'b1);
    chk("early_err", int'(load_error), 1);
    chk("early_fill", int'(fill_count), 0);
    chk("early_valid", int'(operands_valid), 0);
    chk("early_A11_kept", int'(A_11), 10);
    chk("early_A22_untouched", int'(A_22), -128);
    @(posedge clk); #1;
    chk("early_err_pulse", int'(load_error), 0);

    // 12th element without in_last
    for (int k = 0; k < 12; k++) push(20 + k, 1'b0);
    chk("miss_err", int'(load_error), 1);
    chk("miss_fill", int'(fill_count), 0);
    chk("miss_valid", int'(operands_valid), 0);
    chk("miss_B21", int'(B_21), 30);
    chk("miss_B31_untouched", int'(B_31), -128);
    @(posedge clk); #1;
    chk("miss_err_pulse", int'(load_error), 0);

    // Good frame after errors
    for (int k = 0; k < 12; k++) exp_v[k] = k - 5;
    push_frame();
    chk("good_valid", int'(operands_valid), 1);
    chk("good_err", int'(load_error), 0);
    check_ops("good");
    release_ops();

    // Flush after 7 elements, with an element offered in the flush cycle
    for (int k = 0; k < 7; k++) push(40 + k, 1'b0);
    @(negedge clk);
    flush = 1'b1; in_data = 8'sd99; in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("fl_fill", int'(fill_count), 0);
    chk("fl_err", int'(load_error), 0);
    chk("fl_valid", int'(operands_valid), 0);
    chk("fl_in_ready", int'(in_ready), 1);
    chk("fl_A11_kept", int'(A_11), 40);
    chk("fl_A32_not_written", int'(A_32), 2);

    // Flush while FULL
    for (int k = 0; k < 12; k++) exp_v[k] = 60 - 7 * k;
    push_frame();
    chk("flf_valid_pre", int'(operands_valid), 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flf_valid", int'(operands_valid), 0);
    chk("flf_in_ready", int'(in_ready), 1);
    chk("flf_err", int'(load_error), 0);
    chk("flf_A11_kept", int'(A_11), 60);
    for (int k = 0; k < 12; k++) exp_v[k] = 100 - 9 * k;
    push_frame();
    check_ops("post_flush");
    release_ops();

    // Asynchronous reset mid-frame, between edges
    for (int k = 0; k < 3; k++) push(70 + k, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_A11", int'(A_11), 0);
    chk("arst_A13", int'(A_13), 0);
    chk("arst_fill", int'(fill_count), 0);
    chk("arst_valid", int'(operands_valid), 0);
    chk("arst_err", int'(load_error), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame with random idle gaps
    for (int k = 0; k < 12; k++) exp_v[k] = 3 * k - 17;
    for (int k = 0; k < 12; k++) begin
      int gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      push(exp_v[k], k == 11);
    end
    chk("gap_valid", int'(operands_valid), 1);
    check_ops("gap");
    c1 = A_11 * B_11 + A_12 * B_21 + A_13 * B_31;
    chk("gap_C11", c1, (-17) * 10 + (-14) * 13 + (-11) * 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
